// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the thresholded synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDR_WIDTH    = 3;
  localparam int DEFAULT_AFULL_THRESH  = 6;
  localparam int DEFAULT_AEMPTY_THRESH = 2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port storage: one clocked write port, one asynchronous read port.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: storage has no reset; validity is tracked by the pointers, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with registered full/empty/almost flags and sticky error bits.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; default is registered-read mode.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH  = DEFAULT_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH  = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         wptr, rptr, wptr_next, rptr_next, count_next;
  logic                  w_acc, r_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // A write while full is dropped even if a read frees a slot on the same edge.
  assign w_acc = winc && !wfull;
  assign r_acc = rinc && !rempty;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wptr_next = wptr;
    rptr_next = rptr;
    if (clr) begin
      wptr_next = '0;
      rptr_next = '0;
    end else begin
      if (w_acc) wptr_next = wptr + 1'b1;
      if (r_acc) rptr_next = rptr + 1'b1;
    end
    count_next = wptr_next - rptr_next;
  end

  fifo_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (w_acc && !clr),
    .waddr(wptr[ADDR_WIDTH-1:0]),
    .wdata(wdata),
    .raddr(rptr[ADDR_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      count        <= count_next;
      wfull        <= (count_next == DEPTH);
      rempty       <= (count_next == '0);
      almost_full  <= (count_next >= AFULL);
      almost_empty <= (count_next <= AEMPTY);
      if (clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (winc && wfull)  overflow  <= 1'b1;
        if (rinc && rempty) underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible as soon as the FIFO is non-empty.
  assign rdata = rempty ? '0 : mem_rdata;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rdata <= '0;
    else if (r_acc && !clr)  rdata <= mem_rdata;
  end
`endif

endmodule
